pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Parametrised successor to the combinational PC select. Holds the architectural fetch PC in a register and presents it to the instruction-fetch stage with a valid/ready handshake. Arbitrates NUM_REDIR prioritised redirect sources (exception, branch, jump, ...). Latches a redirect that arrives while the fetch stage is busy and applies it on the next accepted fetch, flagging the squashed fetch.

Parameters:
PC_ADDR, 32'h8000_0000, reset/boot PC
ADDR_WIDTH, 32, PC width in bits
NUM_REDIR, 3, number of redirect sources; index 0 = highest priority (deepest pipeline stage)
INC, 4, sequential PC increment in bytes

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
redir_valid_i  in  NUM_REDIR  per-source redirect request
redir_target_i  in  NUM_REDIR*ADDR_WIDTH  per-source target; source k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH]
stall_i  in  1  pipeline stall; holds the PC and withholds valid
if_ready_i  in  1  fetch stage accepts pc_o this cycle
pc_o  out  ADDR_WIDTH  current fetch PC
pc_valid_o  out  1  pc_o offered to fetch
drop_o  out  1  fetch accepted this cycle must be discarded (wrong path)
redir_pending_o  out  1  a captured redirect is waiting to be applied
misalign_o  out  1  one-cycle pulse: applied target had target[1:0] != 0

Behaviour:
- Reset (asynchronous): pc_o=PC_ADDR, pc_valid_o=0, drop_o=0, redir_pending_o=0, misalign_o=0, state=BOOT, pending index=NUM_REDIR (none).
- FSM states:
  - BOOT: one cycle after reset deassertion, then go to RUN.
  - RUN: no redirect pending.
  - PEND: redirect pending.
- pc_valid_o = (state != BOOT) && !stall_i. The handshake HS = pc_valid_o && if_ready_i.
- Arbitration: the winner is the lowest index k with redir_valid_i[k]=1 (sub-module redir_arbiter). Combinational, zero latency.
- RUN, no redirect: on HS, pc_o <= pc_o + INC, modulo 2^ADDR_WIDTH (0xFFFF_FFFC + 4 wraps to 0). No HS: pc_o holds.
- RUN, redirect k, no HS: latch target and index k; go to PEND. pc_o stays stable, because the bus cycle is already in flight.
- RUN, redirect k with HS in the same cycle: pc_o <= target_k and drop_o=1 this cycle. Stay in RUN.
- PEND, new redirect k arriving: replaces the pending target only if k <= pending index; otherwise ignored.
- PEND with HS: pc_o <= effective target, where effective = the arriving winner if it qualifies, else the pending target. drop_o=1 this cycle. Go to RUN and clear the pending index.
- drop_o is combinational: HS && (PEND || any redir_valid_i). It is never asserted without HS.
- misalign_o: registered pulse in the cycle after a redirect target with [1:0]!=0 is loaded into pc_o. The PC is loaded unmodified.
- stall_i=1: no HS and pc_o holds. Redirects are still captured per the rules above.
- redir_pending_o = (state == PEND).
- Reset mid-PEND: the pending redirect is discarded and the PC restarts at PC_ADDR.
- pc_o is registered only; it never changes combinationally while pc_valid_o=1 and if_ready_i=0.

Decomposition:
- Package pc_pkg holds:
  - pc_state_e enum {BOOT, RUN, PEND}
  - default constants PC_RESET=32'h8000_0000 and PC_INC=4
  - REDIR_EXC=0, REDIR_BR=1, REDIR_JMP=2 source indices
- Sub-module redir_arbiter (NUM_REDIR, ADDR_WIDTH): fixed-priority encoder. Outputs any_valid, win_idx and win_target.

Test Plan:
- Boot: release rst_i, hold if_ready_i=1 -> pc_valid_o=0 for 1 cycle, then pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008, with drop_o=0.
- Redirect with HS: at pc 0x8000_0008, redir_valid_i=3'b010, target 0x8000_0100, if_ready_i=1 -> drop_o=1 that cycle; next pc_o=0x8000_0100.
- Redirect while busy: if_ready_i=0 for 3 cycles, one-cycle redirect on source 2 to 0x8000_0200 -> redir_pending_o=1 and pc_o stable. On if_ready_i=1: drop_o=1, next pc_o=0x8000_0200.
- Priority while pending: pending source 2 (0x200), then source 0 (0x8000_0010) while busy, then source 1 (0x300) -> on HS pc_o=0x8000_0010.
- Stall and wrap: force pc to 0xFFFF_FFFC via redirect; stall_i=1 for 2 cycles -> pc_valid_o=0 and pc_o held. Release -> next pc_o=0x0000_0000.
- Misalign and async reset: redirect target 0x8000_0102 -> pc_o=0x8000_0102, misalign_o pulses 1 cycle. Then assert rst_i mid-cycle while PEND -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-PC successor logic.
//   pc_state_e : FSM states of pc_next_unit (BOOT, RUN, PEND)
//   PC_RESET   : default boot PC
//   PC_INC     : default sequential increment in bytes
//   REDIR_*    : redirect source indices, 0 = highest priority
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET = 32'h8000_0000;
  localparam int          PC_INC   = 4;

  localparam int REDIR_EXC = 0;
  localparam int REDIR_BR  = 1;
  localparam int REDIR_JMP = 2;

endpackage

// File: rtl/pc_next_unit_redir_arbiter.sv
// redir_arbiter: fixed-priority selection among NUM_REDIR redirect sources.
//   valid      in  NUM_REDIR             per-source request
//   target     in  NUM_REDIR*ADDR_WIDTH  source k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   any_valid  out 1                     at least one request
//   win_idx    out IDX_W                 lowest requesting index, NUM_REDIR if none
//   win_target out ADDR_WIDTH            target of the winner, zero if none
module redir_arbiter #(
  parameter int NUM_REDIR  = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_W      = $clog2(NUM_REDIR + 1)
) (
  input  logic [NUM_REDIR-1:0]            valid,
  input  logic [NUM_REDIR*ADDR_WIDTH-1:0] target,
  output logic                            any_valid,
  output logic [IDX_W-1:0]                win_idx,
  output logic [ADDR_WIDTH-1:0]           win_target
);

  // Scan from lowest to highest priority so the lowest index overwrites last.
  always_comb begin
    any_valid  = 1'b0;
    win_idx    = IDX_W'(NUM_REDIR);
    win_target = '0;
    for (int k = NUM_REDIR - 1; k >= 0; k--) begin
      if (valid[k]) begin
        any_valid  = 1'b1;
        win_idx    = IDX_W'(k);
        win_target = target[k*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: architectural fetch-PC register with redirect arbitration.
//   clk_i           in  1                    clock
//   rst_i           in  1                    asynchronous reset, active-high
//   redir_valid_i   in  NUM_REDIR            per-source redirect request
//   redir_target_i  in  NUM_REDIR*ADDR_WIDTH per-source redirect target
//   stall_i         in  1                    holds the PC and withholds valid
//   if_ready_i      in  1                    fetch stage accepts pc_o
//   pc_o            out ADDR_WIDTH           current fetch PC (registered)
//   pc_valid_o      out 1                    pc_o offered to fetch
//   drop_o          out 1                    accepted fetch is wrong-path
//   redir_pending_o out 1                    a captured redirect is waiting
//   misalign_o      out 1                    pulse after loading a misaligned target
//
// Handshake: pc_o is transferred in a cycle where pc_valid_o && if_ready_i.
// While pc_valid_o is high and the transfer has not happened, pc_o stays
// stable; it only ever changes at a clock edge.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR    = ADDR_WIDTH'(PC_RESET),
  parameter int                    NUM_REDIR  = 3,
  parameter int                    INC        = PC_INC
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NUM_REDIR-1:0]            redir_valid_i,
  input  logic [NUM_REDIR*ADDR_WIDTH-1:0] redir_target_i,
  input  logic                            stall_i,
  input  logic                            if_ready_i,
  output logic [ADDR_WIDTH-1:0]           pc_o,
  output logic                            pc_valid_o,
  output logic                            drop_o,
  output logic                            redir_pending_o,
  output logic                            misalign_o
);

  localparam int              IDX_W    = $clog2(NUM_REDIR + 1);
  localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_REDIR);

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [IDX_W-1:0]      pend_idx_q, pend_idx_d;
  logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                  misalign_q, misalign_d;
  logic                  load_redir;

  logic                  any_valid;
  logic [IDX_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_target;
  logic                  hs;
  logic                  win_qual;

  redir_arbiter #(
    .NUM_REDIR  (NUM_REDIR),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_arb (
    .valid      (redir_valid_i),
    .target     (redir_target_i),
    .any_valid  (any_valid),
    .win_idx    (win_idx),
    .win_target (win_target)
  );

  assign pc_valid_o      = (state_q != BOOT) && !stall_i;
  assign hs              = pc_valid_o && if_ready_i;
  assign drop_o          = hs && ((state_q == PEND) || any_valid);
  assign redir_pending_o = (state_q == PEND);
  assign pc_o            = pc_q;
  assign misalign_o      = misalign_q;

  // An arriving redirect only displaces a pending one of equal or lower
  // priority; outside PEND the pending index is NONE, so anything qualifies.
  assign win_qual = any_valid && (win_idx <= pend_idx_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    load_redir = 1'b0;
    unique case (state_q)
      BOOT: begin
        // No handshake is possible yet, so a redirect can only be captured.
        if (any_valid) begin
          pend_idx_d = win_idx;
          pend_tgt_d = win_target;
          state_d    = PEND;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (any_valid) begin
          if (hs) begin
            pc_d       = win_target;
            load_redir = 1'b1;
          end else begin
            // The current fetch is still on the bus; keep pc_o and defer.
            pend_idx_d = win_idx;
            pend_tgt_d = win_target;
            state_d    = PEND;
          end
        end else if (hs) begin
          pc_d = pc_q + ADDR_WIDTH'(INC);
        end
      end
      PEND: begin
        if (hs) begin
          pc_d       = win_qual ? win_target : pend_tgt_q;
          load_redir = 1'b1;
          pend_idx_d = IDX_NONE;
          state_d    = RUN;
        end else if (win_qual) begin
          pend_idx_d = win_idx;
          pend_tgt_d = win_target;
        end
      end
      default: begin
        state_d    = BOOT;
        pend_idx_d = IDX_NONE;
      end
    endcase
  end

  assign misalign_d = load_redir && (pc_d[1:0] != 2'b00);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= BOOT;
      pc_q       <= PC_ADDR;
      pend_idx_q <= IDX_NONE;
      pend_tgt_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_idx_q <= pend_idx_d;
      pend_tgt_q <= pend_tgt_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed, table-driven bench for pc_next_unit.
module tb_pc_next_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  redir_valid;
  logic [95:0] redir_target;
  logic        stall;
  logic        if_ready;
  logic [31:0] pc;
  logic        pc_valid;
  logic        drop;
  logic        redir_pending;
  logic        misalign;

  int n_checks = 0;
  int n_pass   = 0;

  pc_next_unit dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .redir_valid_i   (redir_valid),
    .redir_target_i  (redir_target),
    .stall_i         (stall),
    .if_ready_i      (if_ready),
    .pc_o            (pc),
    .pc_valid_o      (pc_valid),
    .drop_o          (drop),
    .redir_pending_o (redir_pending),
    .misalign_o      (misalign)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0]  v;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
    logic        stall;
    logic        rdy;
    logic [31:0] pc;
    logic        valid;
    logic        drop;
    logic        pend;
    logic        mis;
  } vec_t;

  localparam int NV = 29;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [2:0] v, logic [31:0] t0, logic [31:0] t1,
                              logic [31:0] t2, logic st, logic rdy, logic [31:0] epc,
                              logic ev, logic ed, logic ep, logic em);
    vec_t r;
    r.v = v; r.t0 = t0; r.t1 = t1; r.t2 = t2; r.stall = st; r.rdy = rdy;
    r.pc = epc; r.valid = ev; r.drop = ed; r.pend = ep; r.mis = em;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ev,
                         input logic ed, input logic ep, input logic em);
    chk({tag, ".pc"},    pc, epc);
    chk({tag, ".valid"}, {31'b0, pc_valid}, {31'b0, ev});
    chk({tag, ".drop"},  {31'b0, drop}, {31'b0, ed});
    chk({tag, ".pend"},  {31'b0, redir_pending}, {31'b0, ep});
    chk({tag, ".mis"},   {31'b0, misalign}, {31'b0, em});
  endtask

  // driver: caller is at posedge+1; drive, settle, compare, advance one cycle
  task automatic drive(input logic [2:0] v, input logic [31:0] t0, input logic [31:0] t1,
                       input logic [31:0] t2, input logic st, input logic rdy);
    redir_valid  = v;
    redir_target = {t2, t1, t0};
    stall        = st;
    if_ready     = rdy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                v       t0            t1            t2            st rdy  pc            vl dr pe mi
    vecs[0]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 1, 32'h8000_0000, 0, 0, 0, 0); // BOOT
    vecs[1]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 1, 32'h8000_0000, 1, 0, 0, 0);
    vecs[2]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 1, 32'h8000_0004, 1, 0, 0, 0);
    vecs[3]  = mk(3'b010, 32'h0,        32'h8000_0100, 32'h0,       0, 1, 32'h8000_0008, 1, 1, 0, 0); // redirect + HS
    vecs[4]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0100, 1, 0, 0, 0);
    vecs[5]  = mk(3'b100, 32'h0,        32'h0,        32'h8000_0200, 0, 0, 32'h8000_0100, 1, 0, 0, 0); // busy capture
    vecs[6]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0100, 1, 0, 1, 0);
    vecs[7]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0100, 1, 0, 1, 0);
    vecs[8]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 1, 32'h8000_0100, 1, 1, 1, 0); // apply pending
    vecs[9]  = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0200, 1, 0, 0, 0);
    vecs[10] = mk(3'b100, 32'h0,        32'h0,        32'h8000_0200, 0, 0, 32'h8000_0200, 1, 0, 0, 0); // priority
    vecs[11] = mk(3'b001, 32'h8000_0010, 32'h0,       32'h0,        0, 0, 32'h8000_0200, 1, 0, 1, 0);
    vecs[12] = mk(3'b010, 32'h0,        32'h8000_0300, 32'h0,       0, 0, 32'h8000_0200, 1, 0, 1, 0);
    vecs[13] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 1, 32'h8000_0200, 1, 1, 1, 0);
    vecs[14] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0010, 1, 0, 0, 0);
    vecs[15] = mk(3'b001, 32'hFFFF_FFFC, 32'h0,       32'h0,        0, 1, 32'h8000_0010, 1, 1, 0, 0); // stall/wrap
    vecs[16] = mk(3'b000, 32'h0,        32'h0,        32'h0,        1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    vecs[17] = mk(3'b000, 32'h0,        32'h0,        32'h0,        1, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    vecs[18] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    vecs[19] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0000_0000, 1, 0, 0, 0);
    vecs[20] = mk(3'b010, 32'h0,        32'h8000_0102, 32'h0,       0, 1, 32'h0000_0000, 1, 1, 0, 0); // misalign
    vecs[21] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0102, 1, 0, 0, 1);
    vecs[22] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0102, 1, 0, 0, 0);
    vecs[23] = mk(3'b100, 32'h0,        32'h0,        32'h8000_0400, 1, 1, 32'h8000_0102, 0, 0, 0, 0); // capture in stall
    vecs[24] = mk(3'b001, 32'h8000_0500, 32'h0,       32'h0,        0, 1, 32'h8000_0102, 1, 1, 1, 0); // qualifying + HS
    vecs[25] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0500, 1, 0, 0, 0);
    vecs[26] = mk(3'b010, 32'h0,        32'h8000_0600, 32'h0,       0, 0, 32'h8000_0500, 1, 0, 0, 0);
    vecs[27] = mk(3'b100, 32'h0,        32'h0,        32'h8000_0700, 0, 1, 32'h8000_0500, 1, 1, 1, 0); // non-qualifying + HS
    vecs[28] = mk(3'b000, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8000_0600, 1, 0, 0, 0);

    rst = 1'b1;
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    next_cycle();
    next_cycle();
    chk_all("reset", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].v, vecs[i].t0, vecs[i].t1, vecs[i].t2, vecs[i].stall, vecs[i].rdy);
      #2;
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].valid, vecs[i].drop,
              vecs[i].pend, vecs[i].mis);
      next_cycle();
    end

    // misaligned load, then capture a redirect, then async reset mid-PEND
    drive(3'b100, 32'h0, 32'h0, 32'h8000_0802, 1'b0, 1'b1);
    #2;
    chk_all("mis_load", 32'h8000_0600, 1'b1, 1'b1, 1'b0, 1'b0);
    next_cycle();
    drive(3'b001, 32'h8000_0900, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    chk_all("mis_pulse", 32'h8000_0802, 1'b1, 1'b0, 1'b0, 1'b1);
    next_cycle();
    drive(3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    #1;
    chk_all("pend_pre_rst", 32'h8000_0802, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
    #2;
    chk_all("post_rst_boot", 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    next_cycle();
    #2;
    chk_all("post_rst_run", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    next_cycle();
    #2;
    chk_all("post_rst_inc", 32'h8000_0004, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
